// File: rtl/ddr3_mc_arbiter.sv
// ddr3_mc_arbiter: round-robin burst arbiter in front of a MIG DDR3 user port.
// Clients request whole bursts; one burst runs at a time. Read ownership is
// remembered in a tag FIFO so returning MIG read beats are steered to the
// channel that issued them.
//
// Handshake semantics, used by every interface of this block:
//   - A MIG command beat is transferred in a cycle where app_en=1 and app_rdy=1;
//     a write beat additionally needs app_wdf_rdy=1 in that same cycle. While a
//     beat is not transferred, address, command, enable and write data are held.
//   - ch_grant is a one-cycle pulse: the request fields were captured on the
//     clock edge that raised it, and the client may change them afterwards.
//   - ch_wdata is show-ahead: ch_wdata_ack pops the current word, and the
//     client presents the next word from the following cycle.
//   - rd_valid is a one-cycle, one-hot strobe qualifying rd_data.
module ddr3_mc_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 4,
  parameter int TAG_DEPTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init_calib_complete,
  input  logic [NUM_CH-1:0]             ch_req,
  input  logic [NUM_CH-1:0]             ch_rnw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]  ch_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]   ch_len,
  output logic [NUM_CH-1:0]             ch_grant,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]             ch_wdata_ack,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_CH-1:0]             rd_valid,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [DATA_WIDTH-1:0]         app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]       app_wdf_mask,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  input  logic                          app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]         app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic                          busy,
  output logic [1:0]                    dbg_state_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [CH_W-1:0]       sel_q, sel_d;
  logic [NUM_CH-1:0]     grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;

  logic [CH_W-1:0]       tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_CH-1:0]     rd_valid_q;

  logic [NUM_CH-1:0]     elig;
  logic                  pick_found;
  logic [CH_W-1:0]       pick_idx;
  logic                  beat_acc;
  logic                  wr_acc;
  logic                  tag_push;
  logic                  tag_pop;
  int                    tag_free;

  assign tag_free = TAG_DEPTH - int'(cnt_q);
  assign wr_acc   = (state_q == ST_WR) && app_rdy && app_wdf_rdy;
  assign tag_push = (state_q == ST_RD) && app_rdy;
  assign tag_pop  = app_rd_data_valid && (cnt_q != '0);
  assign beat_acc = wr_acc || tag_push;

  // A read is only eligible if the tag FIFO can absorb its whole burst.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_req[i] &
                (~ch_rnw[i] | (tag_free >= int'(ch_len[i*LEN_WIDTH +: LEN_WIDTH]) + 1));
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!pick_found && elig[(int'(rr_q) + k) % NUM_CH]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
  end

  // Burst FSM next state: grant and capture in IDLE, count beats in a burst.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    grant_d = '0;
    addr_d  = addr_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (init_calib_complete && pick_found) begin
          grant_d = NUM_CH'(1) << pick_idx;
          rr_d    = pick_idx;
          sel_d   = pick_idx;
          addr_d  = ch_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          beats_d = ch_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
          state_d = ch_rnw[pick_idx] ? ST_RD : ST_WR;
        end
      end
      ST_WR, ST_RD: begin
        if (beat_acc) begin
          addr_d = addr_q + ADDR_WIDTH'(8);
          if (beats_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beats_d = beats_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst FSM and captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= CH_W'(NUM_CH - 1);
      sel_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  // Tag FIFO occupancy; push and pop in one cycle leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({tag_push, tag_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag storage holds the issuing channel of each outstanding read beat.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[wr_ptr_q] <= sel_q;
    end
  end

  // Tag pointers, count and the registered read-return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (tag_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (tag_pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        rd_valid_q <= NUM_CH'(1) << tag_mem[rd_ptr_q];
      end else begin
        rd_valid_q <= '0;
      end
      if (app_rd_data_valid) begin
        rd_data_q <= app_rd_data;
      end
    end
  end

  assign ch_grant     = grant_q;
  assign app_en       = (state_q != ST_IDLE);
  assign app_cmd      = (state_q == ST_RD) ? 3'b001 : 3'b000;
  assign app_addr     = addr_q;
  assign app_wdf_wren = (state_q == ST_WR);
  assign app_wdf_end  = (state_q == ST_WR);
  assign app_wdf_data = (state_q == ST_WR) ? ch_wdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH]
                                           : '0;
  assign app_wdf_mask = '0;
  assign ch_wdata_ack = wr_acc ? (NUM_CH'(1) << sel_q) : '0;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q != ST_IDLE) || (cnt_q != '0);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ddr3_mc_arbiter.sv
// tb_ddr3_mc_arbiter: directed bench for the DDR3 burst arbiter.
module tb_ddr3_mc_arbiter;

  localparam int NUM_CH = 4;
  localparam int AW     = 28;
  localparam int DW     = 512;
  localparam int LW     = 4;

  logic                clk;
  logic                rst_n;
  logic                init_calib_complete;
  logic [NUM_CH-1:0]   ch_req;
  logic [NUM_CH-1:0]   ch_rnw;
  logic [NUM_CH*AW-1:0] ch_addr;
  logic [NUM_CH*LW-1:0] ch_len;
  logic [NUM_CH-1:0]   ch_grant;
  logic [NUM_CH*DW-1:0] ch_wdata;
  logic [NUM_CH-1:0]   ch_wdata_ack;
  logic [DW-1:0]       rd_data;
  logic [NUM_CH-1:0]   rd_valid;
  logic [AW-1:0]       app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DW-1:0]       app_wdf_data;
  logic [DW/8-1:0]     app_wdf_mask;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic                app_wdf_rdy;
  logic [DW-1:0]       app_rd_data;
  logic                app_rd_data_valid;
  logic                busy;
  logic [1:0]          dbg_state_o;

  ddr3_mc_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .ch_req              (ch_req),
    .ch_rnw              (ch_rnw),
    .ch_addr             (ch_addr),
    .ch_len              (ch_len),
    .ch_grant            (ch_grant),
    .ch_wdata            (ch_wdata),
    .ch_wdata_ack        (ch_wdata_ack),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .busy                (busy),
    .dbg_state_o         (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  logic [NUM_CH-1:0] exp_q[$];   // expected rd_valid owner per returned beat
  logic [NUM_CH-1:0] exp_rv;
  logic [DW-1:0]     exp_rd;
  logic              chk_pend;
  int                ret_left;
  int                ret_seq;

  int                wren_cnt = 0;
  int                ack_cnt  = 0;
  logic [NUM_CH-1:0] ack_last = '0;

  // Counts write strobes and data pops as seen on each active edge.
  always @(posedge clk) begin
    if (app_wdf_wren) wren_cnt <= wren_cnt + 1;
    if (ch_wdata_ack != '0) begin
      ack_cnt  <= ack_cnt + 1;
      ack_last <= ch_wdata_ack;
    end
  end

  typedef struct packed {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [DW-1:0] wpat(input int a, input int b);
    logic [31:0] w;
    w = 32'(a * 65536 + b);
    return {(DW/32){w}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic rnw, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ch_rnw[i]          = rnw;
    ch_addr[i*AW +: AW] = a;
    ch_len[i*LW +: LW]  = l;
  endtask

  // One cycle: check the read return predicted last cycle, drive the next.
  task automatic tick();
    @(negedge clk);
    if (chk_pend) begin
      chk("rd_valid", rd_valid, exp_rv);
      if (exp_rv != '0) chk("rd_data", rd_data, exp_rd);
      chk_pend = 1'b0;
    end
    if (ret_left > 0) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = wpat(99, ret_seq);
      exp_rd            = app_rd_data;
      exp_rv            = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk_pend          = 1'b1;
      ret_left--;
      ret_seq++;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  endtask

  task automatic wait_grant(output logic [NUM_CH-1:0] g);
    g = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (ch_grant != '0) begin
        g = ch_grant;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60; n++) begin
      tick();
      if (!app_en) break;
    end
    chk("burst_end", app_en, 1'b0);
  endtask

  task automatic push_exp(input int n, input logic [NUM_CH-1:0] owner);
    for (int k = 0; k < n; k++) exp_q.push_back(owner);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_CH-1:0] g;
    logic [NUM_CH-1:0] acc;
    logic              acc_en;
    int                w0, a0, j;

    vecs[0]  = '{req: 4'b1111, gnt: 4'b0001};
    vecs[1]  = '{req: 4'b1111, gnt: 4'b0010};
    vecs[2]  = '{req: 4'b1111, gnt: 4'b0100};
    vecs[3]  = '{req: 4'b1111, gnt: 4'b1000};
    vecs[4]  = '{req: 4'b1111, gnt: 4'b0001};
    vecs[5]  = '{req: 4'b1010, gnt: 4'b0010};
    vecs[6]  = '{req: 4'b1010, gnt: 4'b1000};
    vecs[7]  = '{req: 4'b0101, gnt: 4'b0001};
    vecs[8]  = '{req: 4'b0101, gnt: 4'b0100};
    vecs[9]  = '{req: 4'b0011, gnt: 4'b0001};
    vecs[10] = '{req: 4'b1000, gnt: 4'b1000};
    vecs[11] = '{req: 4'b1001, gnt: 4'b0001};
    vecs[12] = '{req: 4'b1100, gnt: 4'b0100};

    rst_n = 1'b0; init_calib_complete = 1'b0;
    ch_req = '0; ch_rnw = '0; ch_addr = '0; ch_len = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    chk_pend = 1'b0; ret_left = 0; ret_seq = 0; exp_rv = '0; exp_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wdata[i*DW +: DW] = wpat(i, 7);
      set_ch(i, 1'b0, AW'(i * 256), '0);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren_end", {app_wdf_wren, app_wdf_end}, 2'b00);
    chk("rst_grant_ack", {ch_grant, ch_wdata_ack}, '0);
    chk("rst_rd", {rd_valid, rd_data}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr_cmd", {app_addr, app_cmd}, '0);
    chk("rst_state", dbg_state_o, 2'd0);
    rst_n = 1'b1;

    // No grant while calibration is pending
    ch_req = 4'b1111;
    acc = '0; acc_en = 1'b0;
    repeat (5) begin
      tick();
      acc    = acc | ch_grant;
      acc_en = acc_en | app_en;
    end
    chk("calib_no_grant", acc, '0);
    chk("calib_no_en", acc_en, 1'b0);
    init_calib_complete = 1'b1;

    // Table: single-beat writes, round-robin order
    for (int v = 0; v < 13; v++) begin
      ch_req = vecs[v].req;
      w0 = wren_cnt; a0 = ack_cnt;
      wait_grant(g);
      chk($sformatf("vec%0d_grant", v), g, vecs[v].gnt);
      j = 0;
      for (int i = 0; i < NUM_CH; i++) if (vecs[v].gnt[i]) j = i;
      chk($sformatf("vec%0d_wdata", v), app_wdf_data, wpat(j, 7));
      chk($sformatf("vec%0d_addr", v), app_addr, AW'(j * 256));
      chk($sformatf("vec%0d_cmd_end_mask", v), {app_cmd, app_wdf_end, app_wdf_mask}, {3'b000, 1'b1, 64'h0});
      wait_idle();
      chk($sformatf("vec%0d_wren_cnt", v), 32'(wren_cnt - w0), 32'd1);
      chk($sformatf("vec%0d_ack_cnt", v), 32'(ack_cnt - a0), 32'd1);
      chk($sformatf("vec%0d_ack_owner", v), ack_last, vecs[v].gnt);
      chk($sformatf("vec%0d_grant_pulse", v), ch_grant, '0);
    end
    ch_req = '0;

    // Two-beat write wrapping the address, write data path stalled 3 cycles
    set_ch(1, 1'b0, 28'h0FFFFFF8, 4'd1);
    app_wdf_rdy = 1'b0;
    ch_req = 4'b0010;
    a0 = ack_cnt;
    wait_grant(g);
    ch_req = '0;
    chk("wrap_grant", g, 4'b0010);
    chk("wrap_addr0", app_addr, 28'h0FFFFFF8);
    chk("wrap_data0", app_wdf_data, wpat(1, 7));
    repeat (3) begin
      chk("wrap_stall_ack", ch_wdata_ack, '0);
      tick();
      chk("wrap_stall_addr", app_addr, 28'h0FFFFFF8);
      chk("wrap_stall_data", app_wdf_data, wpat(1, 7));
    end
    app_wdf_rdy = 1'b1;
    #1;
    chk("wrap_ack0", ch_wdata_ack, 4'b0010);
    tick();
    chk("wrap_addr1", app_addr, 28'h0000000);
    ch_wdata[1*DW +: DW] = wpat(1, 8);
    #1;
    chk("wrap_data1", app_wdf_data, wpat(1, 8));
    tick();
    chk("wrap_done", app_en, 1'b0);
    chk("wrap_ack_cnt", 32'(ack_cnt - a0), 32'd2);

    // Read bursts from ch2 (4 beats) then ch0 (2 beats), data returned later
    set_ch(2, 1'b1, 28'h100, 4'd3);
    ch_req = 4'b0100;
    wait_grant(g);
    ch_req = '0;
    chk("rd2_grant", g, 4'b0100);
    chk("rd2_cmd_addr", {app_cmd, app_addr}, {3'b001, 28'h100});
    push_exp(4, 4'b0100);
    wait_idle();
    chk("rd2_end_addr", app_addr, 28'h120);
    set_ch(0, 1'b1, 28'h200, 4'd1);
    ch_req = 4'b0001;
    wait_grant(g);
    ch_req = '0;
    chk("rd0_grant", g, 4'b0001);
    push_exp(2, 4'b0001);
    wait_idle();
    chk("rd_busy_tags", busy, 1'b1);
    ret_left = 6;
    repeat (7) tick();
    chk("rd_all_returned", 32'(exp_q.size()), 32'd0);
    chk("rd_busy_clear", busy, 1'b0);

    // Stray return with no outstanding tag is dropped
    ret_left = 1;
    repeat (2) tick();
    chk("stray_busy", busy, 1'b0);

    // Tag FIFO nearly full: 30 tags outstanding, ch3 read of 4 must wait
    set_ch(1, 1'b1, 28'h1000, 4'd15);
    ch_req = 4'b0010;
    wait_grant(g);
    ch_req = '0;
    chk("fill1_grant", g, 4'b0010);
    push_exp(16, 4'b0010);
    wait_idle();
    set_ch(2, 1'b1, 28'h2000, 4'd13);
    ch_req = 4'b0100;
    wait_grant(g);
    ch_req = '0;
    chk("fill2_grant", g, 4'b0100);
    push_exp(14, 4'b0100);
    wait_idle();
    set_ch(3, 1'b1, 28'h3000, 4'd3);
    set_ch(0, 1'b0, 28'h40, 4'd0);
    ch_req = 4'b1001;
    wait_grant(g);
    chk("full_skip_grant", g, 4'b0001);
    ch_req = 4'b1000;
    wait_idle();
    acc = '0;
    repeat (4) begin tick(); acc = acc | ch_grant; end
    chk("full_2free_wait", acc, '0);
    ret_left = 1;
    acc = '0;
    repeat (4) begin tick(); acc = acc | ch_grant; end
    chk("full_3free_wait", acc, '0);
    ret_left = 1;
    wait_grant(g);
    ch_req = '0;
    chk("full_4free_grant", g, 4'b1000);
    push_exp(4, 4'b1000);
    ret_left = 32;
    repeat (34) tick();
    chk("full_all_returned", 32'(exp_q.size()), 32'd0);
    chk("full_busy_clear", {busy, app_en}, 2'b00);

    // Reset in the middle of a read burst
    set_ch(1, 1'b1, 28'h500, 4'd7);
    ch_req = 4'b0010;
    wait_grant(g);
    ch_req = '0;
    chk("mid_grant", g, 4'b0010);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en_cmd", {app_en, app_cmd}, 4'b0000);
    chk("mid_rst_addr", app_addr, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rd", {rd_valid, rd_data}, '0);
    chk("mid_rst_state", dbg_state_o, 2'd0);
    chk_pend = 1'b0; ret_left = 0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b0, AW'(i * 256), '0);
    ch_req = 4'b1111;
    wait_grant(g);
    ch_req = '0;
    chk("post_rst_grant", g, 4'b0001);
    wait_idle();
    chk("post_rst_busy", busy, 1'b0);
    ret_left = 1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
